// File: rtl/myo_status_frame_builder_if.sv
// Avalon-MM read-master bundle between the status frame builder and the myocontrol slave.
interface myo_status_frame_builder_if;
    logic [15:0] oAVM_ADDRESS;
    logic        oAVM_READ;
    logic [31:0] iAVM_READDATA;
    logic        iAVM_WAITREQUEST;

    modport master (
        output oAVM_ADDRESS,
        output oAVM_READ,
        input  iAVM_READDATA,
        input  iAVM_WAITREQUEST
    );

    modport slave (
        input  oAVM_ADDRESS,
        input  oAVM_READ,
        output iAVM_READDATA,
        output iAVM_WAITREQUEST
    );
endinterface

// File: rtl/myo_status_frame_builder.sv
// Sweeps myocontrol status registers into a double-buffered, byte-addressable status frame.
// Timing: each read takes 3 + W cycles (W = waitrequest stall cycles). With W = 0, oDONE rises
// on the 15*NUMBER_OF_MOTORS+2 rising edge after the edge that accepts iSTART (62 at default).
module myo_status_frame_builder #(
    parameter int         NUMBER_OF_MOTORS = 4,
    parameter int         TIMEOUT_CYCLES   = 255,
    parameter logic [7:0] HEADER_BYTE      = 8'h5A
) (
    input  logic                          iCLK,
    input  logic                          iRESET,
    input  logic                          iSTART,
    input  logic                          iHOLD,
    output logic                          oBUSY,
    output logic                          oDONE,
    output logic                          oTIMEOUT_ERR,
    output logic [7:0]                    oFRAME_SEQ,
    myo_status_frame_builder_if.master    avm,
    input  logic [7:0]                    iRD_INDEX,
    output logic [7:0]                    oRD_DATA
);

    localparam int FRAME_BYTES = 3 + 20 * NUMBER_OF_MOTORS;
    localparam int AW          = $clog2(FRAME_BYTES);

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_ISSUE    = 3'd1;
    localparam logic [2:0] S_WAIT     = 3'd2;
    localparam logic [2:0] S_STORE    = 3'd3;
    localparam logic [2:0] S_CHECKSUM = 3'd4;
    localparam logic [2:0] S_SWAP     = 3'd5;

    logic [2:0]    r_state;
    logic [2:0]    r_field;
    logic [7:0]    r_motor;
    logic [15:0]   r_stall;
    logic [31:0]   r_data;
    logic [7:0]    r_csum;
    logic [AW-1:0] r_wptr;
    logic [7:0]    r_seq;
    logic          r_bank_sel;
    logic [7:0]    r_bank [0:1][0:FRAME_BYTES-1];
    logic          r_busy;
    logic          r_done;
    logic          r_timeout_err;
    logic [7:0]    r_frame_seq;
    logic [15:0]   r_address;
    logic          r_read;
    logic [7:0]    r_rd_data;

    logic          w_wbank;
    logic [7:0]    w_seq_next;
    logic          w_last_read;

    assign w_wbank     = ~r_bank_sel;
    assign w_seq_next  = r_seq + 8'd1;
    assign w_last_read = (r_field == 3'd4) && (r_motor == 8'(NUMBER_OF_MOTORS - 1));

    assign oBUSY            = r_busy;
    assign oDONE            = r_done;
    assign oTIMEOUT_ERR     = r_timeout_err;
    assign oFRAME_SEQ       = r_frame_seq;
    assign avm.oAVM_ADDRESS = r_address;
    assign avm.oAVM_READ    = r_read;
    assign oRD_DATA         = r_rd_data;

    // Register high byte for each payload field, in sweep order.
    function automatic logic [7:0] field_code(input logic [2:0] f);
        case (f)
            3'd0:    return 8'h0B;
            3'd1:    return 8'h0C;
            3'd2:    return 8'h0E;
            3'd3:    return 8'h0D;
            3'd4:    return 8'h0F;
            default: return 8'h00;
        endcase
    endfunction

    function automatic logic [7:0] fold_xor(input logic [31:0] w);
        return w[31:24] ^ w[23:16] ^ w[15:8] ^ w[7:0];
    endfunction

    // Sweep sequencer, write-bank fill and bank swap.
    always_ff @(posedge iCLK) begin
        if (iRESET) begin
            r_state       <= S_IDLE;
            r_field       <= 3'd0;
            r_motor       <= 8'd0;
            r_stall       <= 16'd0;
            r_data        <= 32'd0;
            r_csum        <= 8'h00;
            r_wptr        <= '0;
            r_seq         <= 8'd0;
            r_bank_sel    <= 1'b0;
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
            r_timeout_err <= 1'b0;
            r_frame_seq   <= 8'd0;
            r_address     <= 16'd0;
            r_read        <= 1'b0;
            for (int b = 0; b < 2; b++) begin
                for (int i = 0; i < FRAME_BYTES; i++) begin
                    r_bank[b[0]][i[AW-1:0]] <= 8'h00;
                end
            end
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (iSTART) begin
                        r_busy                  <= 1'b1;
                        r_timeout_err           <= 1'b0;
                        r_seq                   <= w_seq_next;
                        r_bank[w_wbank][AW'(0)] <= HEADER_BYTE;
                        r_bank[w_wbank][AW'(1)] <= w_seq_next;
                        r_csum                  <= HEADER_BYTE ^ w_seq_next;
                        r_field                 <= 3'd0;
                        r_motor                 <= 8'd0;
                        r_wptr                  <= AW'(2);
                        r_state                 <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    r_address <= {field_code(r_field), r_motor};
                    r_read    <= 1'b1;
                    r_stall   <= 16'd0;
                    r_state   <= S_WAIT;
                end
                S_WAIT: begin
                    if (!avm.iAVM_WAITREQUEST) begin
                        r_data  <= avm.iAVM_READDATA;
                        r_read  <= 1'b0;
                        r_state <= S_STORE;
                    end else if (r_stall == 16'(TIMEOUT_CYCLES - 1)) begin
                        // Abandoned read: the all-ones word marks the slot as invalid.
                        r_data        <= 32'hFFFF_FFFF;
                        r_read        <= 1'b0;
                        r_timeout_err <= 1'b1;
                        r_state       <= S_STORE;
                    end else begin
                        r_stall <= r_stall + 16'd1;
                    end
                end
                S_STORE: begin
                    r_bank[w_wbank][r_wptr]          <= r_data[31:24];
                    r_bank[w_wbank][r_wptr + AW'(1)] <= r_data[23:16];
                    r_bank[w_wbank][r_wptr + AW'(2)] <= r_data[15:8];
                    r_bank[w_wbank][r_wptr + AW'(3)] <= r_data[7:0];
                    r_csum <= r_csum ^ fold_xor(r_data);
                    r_wptr <= r_wptr + AW'(4);
                    if (w_last_read) begin
                        r_state <= S_CHECKSUM;
                    end else if (r_motor == 8'(NUMBER_OF_MOTORS - 1)) begin
                        r_motor <= 8'd0;
                        r_field <= r_field + 3'd1;
                        r_state <= S_ISSUE;
                    end else begin
                        r_motor <= r_motor + 8'd1;
                        r_state <= S_ISSUE;
                    end
                end
                S_CHECKSUM: begin
                    r_bank[w_wbank][AW'(FRAME_BYTES - 1)] <= r_csum;
                    r_state <= S_SWAP;
                end
                S_SWAP: begin
                    if (!iHOLD) begin
                        r_bank_sel  <= ~r_bank_sel;
                        r_frame_seq <= r_seq;
                        r_done      <= 1'b1;
                        r_busy      <= 1'b0;
                        r_state     <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_read  <= 1'b0;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    // Registered read port, always from the bank not being filled.
    always_ff @(posedge iCLK) begin
        if (iRESET) begin
            r_rd_data <= 8'h00;
        end else if (iRD_INDEX < 8'(FRAME_BYTES)) begin
            r_rd_data <= r_bank[r_bank_sel][iRD_INDEX[AW-1:0]];
        end else begin
            r_rd_data <= 8'h00;
        end
    end

endmodule

// File: tb/tb_myo_status_frame_builder.sv
// Randomised-index, scenario-driven bench for myo_status_frame_builder with a frame-level reference model.
module tb_myo_status_frame_builder;

    localparam int          N       = 4;
    localparam int          FB      = 3 + 20 * N;
    localparam int          TMO     = 255;
    localparam logic [15:0] NO_HANG = 16'hFFFF;

    logic       clk;
    logic       rst;
    logic       start;
    logic       hold;
    logic       busy;
    logic       done;
    logic       terr;
    logic [7:0] fseq;
    logic [7:0] rd_index;
    logic [7:0] rd_data;

    myo_status_frame_builder_if avm_bus();

    myo_status_frame_builder #(
        .NUMBER_OF_MOTORS (N),
        .TIMEOUT_CYCLES   (TMO),
        .HEADER_BYTE      (8'h5A)
    ) dut (
        .iCLK         (clk),
        .iRESET       (rst),
        .iSTART       (start),
        .iHOLD        (hold),
        .oBUSY        (busy),
        .oDONE        (done),
        .oTIMEOUT_ERR (terr),
        .oFRAME_SEQ   (fseq),
        .avm          (avm_bus),
        .iRD_INDEX    (rd_index),
        .oRD_DATA     (rd_data)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int checks = 0;
    int errors = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual %0h, required %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    logic [7:0]  codes [5] = '{8'h0B, 8'h0C, 8'h0E, 8'h0D, 8'h0F};
    logic [7:0]  model_bank [FB];
    logic [7:0]  pending [FB];
    logic [7:0]  model_seq;
    logic [7:0]  model_seq_out;
    logic [7:0]  exp_rd;
    bit          model_busy = 1'b0;
    bit          started    = 1'b0;
    bit          abort_run  = 1'b0;
    bit          prev_done  = 1'b0;
    bit          rand_idx_en;
    logic [15:0] exp_addr_q [$];
    int          cfg_wait;
    logic [15:0] cfg_hang;
    int          runs_started = 0;
    int          run_len = 0;
    int          done_count = 0;
    logic [15:0] run_addr;

    task automatic build_pending(input logic [7:0] seq, input logic [15:0] hang);
        logic [7:0]  cs;
        logic [31:0] w;
        logic [15:0] a;
        int          p;
        pending[0] = 8'h5A;
        pending[1] = seq;
        p = 2;
        for (int f = 0; f < 5; f++) begin
            for (int m = 0; m < N; m++) begin
                a = {codes[f], 8'(m)};
                exp_addr_q.push_back(a);
                w = (a == hang) ? 32'hFFFF_FFFF : {16'hA000, a};
                for (int k = 0; k < 4; k++) begin
                    pending[p] = w[31 - 8 * k -: 8];
                    p++;
                end
            end
        end
        cs = 8'h00;
        for (int i = 0; i < FB - 1; i++) cs ^= pending[i];
        pending[FB - 1] = cs;
    endtask

    // Rising-edge view: reset, start acceptance and the byte the DUT is about to register.
    initial begin
        forever begin
            @(posedge clk);
            if (rst) begin
                started       = 1'b1;
                model_busy    = 1'b0;
                model_seq     = 8'd0;
                model_seq_out = 8'd0;
                abort_run     = 1'b1;
                exp_rd        = 8'h00;
                for (int i = 0; i < FB; i++) model_bank[i] = 8'h00;
            end else begin
                exp_rd = (int'(rd_index) < FB) ? model_bank[rd_index] : 8'h00;
                if (start && !model_busy) begin
                    model_busy = 1'b1;
                    model_seq  = model_seq + 8'd1;
                    build_pending(model_seq, cfg_hang);
                end
            end
        end
    end

    // Per-cycle compare of read port, done pulse and frame sequence.
    initial begin
        forever begin
            @(negedge clk);
            if (started) begin
                check("rd_data", {24'd0, rd_data}, {24'd0, exp_rd});
                if (done === 1'b1) begin
                    check("done_in_sweep", {31'd0, model_busy}, 32'd1);
                    check("done_single", {31'd0, prev_done}, 32'd0);
                    done_count++;
                    for (int i = 0; i < FB; i++) model_bank[i] = pending[i];
                    model_busy    = 1'b0;
                    model_seq_out = model_seq;
                end
                prev_done = (done === 1'b1);
                check("frame_seq", {24'd0, fseq}, {24'd0, model_seq_out});
            end
        end
    end

    // Behavioural Avalon slave plus read-transaction monitor.
    initial begin
        avm_bus.iAVM_WAITREQUEST = 1'b0;
        avm_bus.iAVM_READDATA    = 32'd0;
        forever begin
            @(negedge clk);
            if (abort_run) begin
                run_len   = 0;
                abort_run = 1'b0;
                exp_addr_q.delete();
            end
            if (started && avm_bus.oAVM_READ === 1'b1) begin
                check("read_in_sweep", {31'd0, model_busy}, 32'd1);
                if (run_len == 0) begin
                    runs_started++;
                    run_addr = avm_bus.oAVM_ADDRESS;
                    if (exp_addr_q.size() == 0) check("extra_read", 32'd1, 32'd0);
                    else check("read_addr", {16'd0, avm_bus.oAVM_ADDRESS}, {16'd0, exp_addr_q.pop_front()});
                end else begin
                    check("addr_stable", {16'd0, avm_bus.oAVM_ADDRESS}, {16'd0, run_addr});
                end
                run_len++;
                avm_bus.iAVM_WAITREQUEST = (avm_bus.oAVM_ADDRESS == cfg_hang) || (run_len <= cfg_wait);
            end else begin
                if (started && run_len > 0)
                    check("read_len", run_len, (run_addr == cfg_hang) ? TMO : cfg_wait + 1);
                run_len = 0;
                avm_bus.iAVM_WAITREQUEST = 1'b0;
            end
            avm_bus.iAVM_READDATA = {16'hA000, avm_bus.oAVM_ADDRESS};
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (rand_idx_en) rd_index = 8'($urandom_range(0, 95));
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic read_byte(input int idx, input logic [7:0] exp, input string nm);
        rand_idx_en = 1'b0;
        @(negedge clk);
        rd_index = 8'(idx);
        @(negedge clk);
        check(nm, {24'd0, rd_data}, {24'd0, exp});
        rand_idx_en = 1'b1;
    endtask

    task automatic sweep(input int w, input logic [15:0] hang, input bit spam, output int lat);
        int r0;
        cfg_wait = w;
        cfg_hang = hang;
        r0 = runs_started;
        lat = -1;
        @(negedge clk);
        start = 1'b1;
        for (int n = 1; n <= 3000; n++) begin
            @(negedge clk);
            start = spam && (((n % 5) == 0 && n < 55) || n == 62);
            if (n == 1) begin
                check("busy_after_start", {31'd0, busy}, 32'd1);
                check("terr_cleared", {31'd0, terr}, 32'd0);
            end
            if (done === 1'b1) begin
                lat = n - 1;
                break;
            end
        end
        start = 1'b0;
        if (lat < 0) begin
            check("done_timeout", 32'd0, 32'd1);
        end else begin
            check("reads_per_sweep", runs_started - r0, 5 * N);
            if (hang == NO_HANG) check("latency", lat, (3 + w) * 5 * N + 2);
        end
    endtask

    initial begin
        #1000000;
        errors++;
        $display("FAIL watchdog: simulation exceeded time limit");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $fatal(1);
    end

    logic [7:0] hdr [6] = '{8'h5A, 8'h01, 8'hA0, 8'h00, 8'h0B, 8'h00};

    initial begin
        int lat;
        int d0;
        int r0;
        bit hit;
        rst = 1'b1; start = 1'b0; hold = 1'b0; rd_index = 8'd0;
        rand_idx_en = 1'b0; cfg_wait = 0; cfg_hang = NO_HANG;
        repeat (3) @(negedge clk);
        rst = 1'b0;

        // Reset / idle state
        check("idle_busy", {31'd0, busy}, 32'd0);
        check("idle_done", {31'd0, done}, 32'd0);
        check("idle_read", {31'd0, avm_bus.oAVM_READ}, 32'd0);
        check("idle_terr", {31'd0, terr}, 32'd0);
        check("idle_seq", {24'd0, fseq}, 32'd0);
        for (int i = 0; i <= 90; i++) read_byte(i, 8'h00, "idle_byte");
        rand_idx_en = 1'b1;

        // Zero-wait sweep
        sweep(0, NO_HANG, 1'b0, lat);
        check("seq_after_first", {24'd0, fseq}, 32'd1);
        d0 = done_count;
        repeat (10) @(negedge clk);
        check("no_extra_done", done_count, d0);
        for (int i = 0; i < 6; i++) read_byte(i, hdr[i], "frame1_head");
        read_byte(82, 8'h5B, "frame1_csum");
        read_byte(83, 8'h00, "beyond_frame");
        read_byte(255, 8'h00, "index_255");

        // Three waitrequest cycles per read
        sweep(3, NO_HANG, 1'b0, lat);
        check("seq_after_wait", {24'd0, fseq}, 32'd2);
        read_byte(1, 8'h02, "frame2_seq");
        read_byte(4, 8'h0B, "frame2_b4");
        read_byte(82, 8'h58, "frame2_csum");

        // Hold blocks the swap
        cfg_wait = 0; cfg_hang = NO_HANG;
        @(negedge clk);
        hold = 1'b1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        d0 = done_count;
        repeat (200) @(negedge clk);
        check("hold_no_done", done_count, d0);
        check("hold_busy", {31'd0, busy}, 32'd1);
        read_byte(1, 8'h02, "hold_old_frame");
        hold = 1'b0;
        @(negedge clk);
        check("hold_release_done", {31'd0, done}, 32'd1);
        read_byte(1, 8'h03, "hold_new_frame");

        // Read that never completes
        sweep(0, 16'h0D02, 1'b0, lat);
        check("terr_set", {31'd0, terr}, 32'd1);
        for (int i = 58; i <= 61; i++) read_byte(i, 8'hFF, "timeout_payload");
        read_byte(57, 8'h01, "before_timeout");
        read_byte(62, 8'hA0, "after_timeout");
        read_byte(82, 8'hF1, "timeout_csum");
        sweep(0, NO_HANG, 1'b0, lat);
        check("terr_after_next", {31'd0, terr}, 32'd0);

        // Repeated iSTART while busy, including on the swap edge
        d0 = done_count;
        sweep(0, NO_HANG, 1'b1, lat);
        repeat (40) @(negedge clk);
        check("spam_idle", {31'd0, busy}, 32'd0);
        check("spam_one_done", done_count, d0 + 1);
        check("spam_seq", {24'd0, fseq}, 32'd6);

        // Reset during the fifth read
        cfg_wait = 3; cfg_hang = NO_HANG;
        r0 = runs_started;
        hit = 1'b0;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int n = 0; n < 500; n++) begin
            if (runs_started - r0 == 5 && avm_bus.oAVM_READ === 1'b1) begin
                hit = 1'b1;
                break;
            end
            @(negedge clk);
        end
        check("fifth_read_seen", {31'd0, hit}, 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("reset_read", {31'd0, avm_bus.oAVM_READ}, 32'd0);
        check("reset_busy", {31'd0, busy}, 32'd0);
        check("reset_seq", {24'd0, fseq}, 32'd0);
        read_byte(0, 8'h00, "reset_byte0");
        read_byte(1, 8'h00, "reset_byte1");
        read_byte(82, 8'h00, "reset_byte82");

        // Sequence wrap over 256 sweeps
        for (int s = 1; s <= 256; s++) begin
            sweep($urandom_range(0, 1), NO_HANG, 1'b0, lat);
            if (s == 255) check("seq_255", {24'd0, fseq}, 32'd255);
        end
        check("seq_wrapped", {24'd0, fseq}, 32'd0);
        read_byte(1, 8'h00, "wrap_byte1");
        read_byte(82, 8'h5A, "wrap_csum");

        repeat (5) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
